// File: rtl/lsu_if.sv
// Execute-side request, data-memory, writeback and error signals of the load/store unit.
// The master modport is the LSU's view and the slave modport is the environment's view.
interface lsu_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic [4:0]  req_rd_i;
  logic        mem_valid_o;
  logic        mem_ready_i;
  logic        mem_memRW_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        stall_o;
  logic        err_misalign_o;
  logic        err_timeout_o;

  modport master (
    input  req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    input  mem_ready_i, mem_rvalid_i, mem_rdata_i,
    output req_ready_o, mem_valid_o, mem_memRW_o, mem_addr_o, mem_wdata_o, mem_be_o,
    output wb_valid_o, wb_rd_o, wb_data_o, stall_o, err_misalign_o, err_timeout_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i, req_rd_i,
    output mem_ready_i, mem_rvalid_i, mem_rdata_i,
    input  req_ready_o, mem_valid_o, mem_memRW_o, mem_addr_o, mem_wdata_o, mem_be_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, stall_o, err_misalign_o, err_timeout_o
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: one op at a time from execute to data memory, with alignment check,
// lane steering, load extension and a per-phase timeout on the memory handshakes.
//
// state  | meaning
// S_IDLE | ready for a new op from execute
// S_REQ  | memory request asserted, waiting for mem_ready_i
// S_WAIT | load accepted by memory, waiting for mem_rvalid_i
// S_RESP | load result presented to writeback for one cycle
// S_ERR  | misaligned or illegal op, error pulse, no memory access
module lsu #(
  parameter int unsigned MAX_WAIT = 15
) (
  input logic   clk,
  input logic   rst,
  lsu_if.master bus
);

  localparam int unsigned   CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_RESP,
    S_ERR
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          cnt_load;
  logic          timeout;
  logic          misalign;

  logic          rw_q;
  logic          uns_q;
  logic [1:0]    size_q;
  logic [1:0]    off_q;
  logic [4:0]    rd_q;
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    be_q;
  logic [31:0]   wb_data_q;
  logic          err_timeout_q;

  logic [3:0]    be_d;
  logic [31:0]   wdata_d;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   load_ext;

  always_comb begin
    misalign = 1'b0;
    case (bus.req_size_i)
      2'b01:   misalign = bus.req_addr_i[0];
      2'b10:   misalign = (bus.req_addr_i[1:0] != 2'b00);
      2'b11:   misalign = 1'b1;
      default: misalign = 1'b0;
    endcase
  end

  // Loads always read the full word; the lane is picked out on the way back.
  always_comb begin
    be_d    = 4'b1111;
    wdata_d = bus.req_wdata_i;
    if (bus.req_we_i) begin
      case (bus.req_size_i)
        2'b00: begin
          be_d    = 4'b0001 << bus.req_addr_i[1:0];
          wdata_d = {4{bus.req_wdata_i[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << bus.req_addr_i[1:0];
          wdata_d = {2{bus.req_wdata_i[15:0]}};
        end
        2'b10:   be_d = 4'b1111;
        default: be_d = 4'b0000;
      endcase
    end
  end

  always_comb begin
    rbyte    = bus.mem_rdata_i[{off_q, 3'b000} +: 8];
    rhalf    = bus.mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    load_ext = bus.mem_rdata_i;
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, rbyte} : {{24{rbyte[7]}}, rbyte};
      2'b01:   load_ext = uns_q ? {16'h0, rhalf} : {{16{rhalf[15]}}, rhalf};
      default: load_ext = bus.mem_rdata_i;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_load = 1'b0;
    timeout  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid_i) begin
          state_d  = misalign ? S_ERR : S_REQ;
          cnt_load = 1'b1;
        end
      end
      S_REQ: begin
        if (bus.mem_ready_i) begin
          state_d  = rw_q ? S_WAIT : S_IDLE;
          cnt_load = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.mem_rvalid_i) begin
          state_d = S_RESP;
        end else if (cnt_q == '0) begin
          state_d = S_IDLE;
          timeout = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Down-counter reloaded on entry to REQ/WAIT; terminal count 0 marks the last allowed cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_load) begin
      cnt_q <= CNT_INIT;
    end else if ((state_q == S_REQ || state_q == S_WAIT) && cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rw_q    <= 1'b1;
      uns_q   <= 1'b0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      rd_q    <= 5'd0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'b0000;
    end else if (state_q == S_IDLE && bus.req_valid_i) begin
      rw_q    <= ~bus.req_we_i;
      uns_q   <= bus.req_unsigned_i;
      size_q  <= bus.req_size_i;
      off_q   <= bus.req_addr_i[1:0];
      rd_q    <= bus.req_rd_i;
      addr_q  <= {bus.req_addr_i[31:2], 2'b00};
      wdata_q <= wdata_d;
      be_q    <= be_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_data_q     <= 32'h0;
      err_timeout_q <= 1'b0;
    end else begin
      err_timeout_q <= timeout;
      if (state_q == S_WAIT && bus.mem_rvalid_i) begin
        wb_data_q <= load_ext;
      end
    end
  end

  assign bus.req_ready_o    = (state_q == S_IDLE);
  assign bus.stall_o        = (state_q != S_IDLE);
  assign bus.mem_valid_o    = (state_q == S_REQ);
  assign bus.mem_memRW_o    = rw_q;
  assign bus.mem_addr_o     = addr_q;
  assign bus.mem_wdata_o    = wdata_q;
  assign bus.mem_be_o       = be_q;
  assign bus.wb_valid_o     = (state_q == S_RESP);
  assign bus.wb_rd_o        = rd_q;
  assign bus.wb_data_o      = wb_data_q;
  assign bus.err_misalign_o = (state_q == S_ERR);
  assign bus.err_timeout_o  = err_timeout_q;

endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting between the execute stage and the data memory: initiator side of the data-memory interface. Accepts one load or store per handshake from execute, checks alignment, drives word-aligned memory requests with byte enables, extracts and sign/zero-extends load data, and returns it to writeback. Stalls the pipeline while a transaction is outstanding and aborts hung accesses with a timeout.

## Interface
- MAX_WAIT, 15: cycles allowed in REQ or WAIT before timeout abort (≥1)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid_i  in  1  execute presents a memory op
- req_ready_o  out  1  LSU can accept (high only in IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned_i  in  1  loads: 1 zero-extend, 0 sign-extend
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- req_rd_i  in  5  load destination register
- mem_valid_o  out  1  request to memory
- mem_ready_i  in  1  memory accepts request
- mem_memRW_o  out  1  0 write, 1 read (memory's convention)
- mem_addr_o  out  32  {req_addr[31:2],2'b00}
- mem_wdata_o  out  32  lane-replicated store data
- mem_be_o  out  4  byte enables
- mem_rvalid_i  in  1  read data valid
- mem_rdata_i  in  32  read data word
- wb_valid_o  out  1  one-cycle pulse: load result valid
- wb_rd_o  out  5  load destination
- wb_data_o  out  32  extended load data
- stall_o  out  1  high whenever state ≠ IDLE
- err_misalign_o  out  1  one-cycle pulse
- err_timeout_o  out  1  one-cycle pulse

## Operation
- States: IDLE, REQ, WAIT, RESP, ERR.
- IDLE: req_ready_o=1. On req_valid_i: register all req fields. Misaligned (half with addr[0]=1, word with addr[1:0]≠0, size 11) → ERR; else → REQ.
- REQ: mem_valid_o=1, address/data/be/memRW held stable. On mem_ready_i: store → IDLE; load → WAIT. Otherwise wait counter increments.
- WAIT: mem_rvalid_i sampled only here; on it, capture extracted data → RESP.
- RESP: wb_valid_o=1 for one cycle with wb_rd_o, wb_data_o → IDLE.
- ERR: err_misalign_o=1 one cycle, no memory access, no wb → IDLE.
- Timeout: counter cleared on entry to REQ and to WAIT; reaching MAX_WAIT without the awaited handshake → err_timeout_o pulse (registered, next cycle, in IDLE), mem_valid_o drops, no wb.
- Store lanes: byte be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}; half be=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}; word be=4'b1111, wdata unchanged.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; extend per req_unsigned_i; word unchanged.
- Loads: mem_be_o=4'b1111, mem_memRW_o=1. Stores: mem_memRW_o=0.

## Timing
- Reset (rst low, async): state IDLE, counter 0, req_ready_o=1, stall_o=0, mem_valid_o=0, mem_memRW_o=1, mem_addr_o/mem_wdata_o/wb_data_o=0, mem_be_o=0, wb_valid_o=0, wb_rd_o=0, both err=0. Reset mid-transaction abandons it: no wb, no error pulse.
- All outputs registered or decoded from registered state; no combinational path req_* → mem_*.
- Accept at edge T; mem_valid_o high from T+1.
- Store minimum: ready at T+1 → req_ready_o high T+2 (2-cycle occupancy).
- Load minimum: ready at T+1, rvalid at T+2 → wb_valid_o at T+3.
- mem_rvalid_i during REQ (including the same cycle as mem_ready_i) is ignored.
- Misaligned: err_misalign_o at T+1, req_ready_o high T+2.
- Timeout: mem_ready_i low for MAX_WAIT cycles from T+1 → err_timeout_o high exactly one cycle, then accept possible.
- Back-to-back: a new request may be accepted the cycle req_ready_o returns high.

## Test plan
- Reset released, no requests → all outputs at reset values, req_ready_o=1, stall_o=0 for 10 cycles.
- SW addr 0x0000_0104 data 0xDEADBEEF, mem_ready_i immediate → mem_addr_o=0x104, mem_be_o=1111, mem_memRW_o=0, mem_wdata_o=0xDEADBEEF, req_ready_o back after 2 cycles; SB addr 0x107 data 0x5A → be=1000, wdata=0x5A5A5A5A.
- LB addr 0x103, rdata 0x80FF_0011 → wb_data_o=0xFFFF_FF80; LBU same → 0x0000_0080; LH addr 0x102 → 0xFFFF_80FF; LW 0x100, rd=7 → 0x80FF_0011, wb_rd_o=7, wb_valid_o one cycle at T+3.
- LW addr 0x102, SH addr 0x101, size 11 → err_misalign_o pulse each, mem_valid_o never asserted, no wb.
- MAX_WAIT=15, mem_ready_i held low → mem_valid_o high 15 cycles, err_timeout_o one pulse, returns IDLE; repeat with ready then rvalid withheld → timeout from WAIT.
- rst asserted during WAIT of a load → outputs to reset values asynchronously; late mem_rvalid_i after release produces no wb_valid_o.
